// File: rtl/alu_32mul_seq.sv
// Sequential signed radix-4 Booth multiplier, one bit-pair per clock, {hi, lo} product.
// Optional macro ALU_MUL_ZERO_BYPASS_EN: zero operand skips straight to DONE.
module alu_32mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   msh_reg;   // multiplicand, sign-extended, pre-shifted by 2i
  logic [WIDTH-1:0] q_reg;    // multiplier, shifted right by 2 each step
  logic            qm1_reg;   // q[2i-1] for the current bit-pair
  logic [PW-1:0]   acc_reg;
  logic [PW-1:0]   pp_reg;
  logic [CW-1:0]   cnt_reg;

  logic [2:0]      booth_sel;
  logic [PW-1:0]   msh2;
  logic [PW-1:0]   pp_next;
  logic [PW-1:0]   acc_sum;
  logic            zero_op;

  assign booth_sel = {q_reg[1:0], qm1_reg};
  assign msh2      = msh_reg << 1;
  assign acc_sum   = acc_reg + pp_reg;

`ifdef ALU_MUL_ZERO_BYPASS_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Partial products are full product width, so +/-2M can never overflow.
  always_comb begin
    pp_next = '0;
    case (booth_sel)
      3'b001, 3'b010: pp_next = msh_reg;
      3'b011:         pp_next = msh2;
      3'b100:         pp_next = -msh2;
      3'b101, 3'b110: pp_next = -msh_reg;
      default:        pp_next = '0;
    endcase
  end

  // The selected partial product is registered and summed one cycle later,
  // which is where the extra cycle of latency beyond WIDTH/2 comes from.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      msh_reg   <= '0;
      q_reg     <= '0;
      qm1_reg   <= 1'b0;
      acc_reg   <= '0;
      pp_reg    <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            msh_reg <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
            q_reg   <= multiplier;
            qm1_reg <= 1'b0;
            acc_reg <= '0;
            pp_reg  <= '0;
            cnt_reg <= '0;
            if (zero_op) begin
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              out       <= '0;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        CALC: begin
          acc_reg <= acc_sum;
          if (cnt_reg == CW'(STEPS)) begin
            out       <= acc_sum;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end else begin
            pp_reg  <= pp_next;
            msh_reg <= msh_reg << 2;
            q_reg   <= q_reg >> 2;
            qm1_reg <= q_reg[1];
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_32mul_seq.sv
// Directed bench for alu_32mul_seq (WIDTH=32); done offsets are counted in clock
// edges after the edge that samples start.
module tb_alu_32mul_seq;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] out;

  int vectors;
  int miscompares;

  localparam int LAT = 17;
`ifdef ALU_MUL_ZERO_BYPASS_EN
  localparam int ZLAT  = 0;
  localparam bit ZBUSY = 1'b0;
`else
  localparam int ZLAT  = 17;
  localparam bit ZBUSY = 1'b1;
`endif

  alu_32mul_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .out          (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts one op and waits (bounded) for done; returns what was observed.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                       output logic [63:0] res, output int lat,
                       output bit busy_seen, output logic done_after);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    lat       = 0;
    busy_seen = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = out;
    @(posedge clk); #1;
    done_after = done;
    $display("op m=%h q=%h out=%h done_edge=%0d", m, q, res, lat);
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (out !== 64'd0) begin miscompares++; $display("FAIL reset_out got=%h exp=0", out); end
    clr_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle busy=%b done=%b exp=0/0", busy, done);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    logic [63:0] r; int lat; bit bs; logic da;
    do_op(32'd7, -32'sd3, r, lat, bs, da);
    vectors++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin miscompares++; $display("FAIL basic_out got=%h exp=ffffffffffffffeb", r); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    vectors++; if (bs !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b exp=1", bs); end
    vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL basic_single_done got=%b exp=0", da); end
    vectors++; if (out !== 64'hFFFF_FFFF_FFFF_FFEB) begin miscompares++; $display("FAIL basic_out_hold got=%h exp=ffffffffffffffeb", out); end
  endtask

  task automatic test_extremes();
    logic [63:0] r; int lat; bit bs; logic da;
    do_op(32'h8000_0000, 32'h8000_0000, r, lat, bs, da);
    vectors++; if (r !== 64'h4000_0000_0000_0000) begin miscompares++; $display("FAIL mostneg_sq got=%h exp=4000000000000000", r); end
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, r, lat, bs, da);
    vectors++; if (r !== 64'h3FFF_FFFF_0000_0001) begin miscompares++; $display("FAIL maxpos_sq got=%h exp=3fffffff00000001", r); end
  endtask

  task automatic test_boundaries();
    logic [31:0] bm [7];
    logic [31:0] bq [7];
    logic [63:0] be [7];
    logic [63:0] r; int lat; bit bs; logic da;
    bm[0] = 32'd0;          bq[0] = 32'd5;          be[0] = 64'd0;
    bm[1] = 32'h1234_5678;  bq[1] = 32'hFFFF_FFFF;  be[1] = 64'hFFFF_FFFF_EDCB_A988;
    bm[2] = 32'h8000_0000;  bq[2] = 32'd3;          be[2] = 64'hFFFF_FFFE_8000_0000;
    bm[3] = 32'h8000_0000;  bq[3] = 32'hFFFF_FFFF;  be[3] = 64'h0000_0000_8000_0000;
    bm[4] = 32'h7FFF_FFFF;  bq[4] = 32'h8000_0000;  be[4] = 64'hC000_0000_8000_0000;
    bm[5] = 32'hFFFF_FFFA;  bq[5] = 32'd4;          be[5] = 64'hFFFF_FFFF_FFFF_FFE8;
    bm[6] = 32'd12345;      bq[6] = 32'd6789;       be[6] = 64'd83810205;
    for (int i = 0; i < 7; i++) begin
      do_op(bm[i], bq[i], r, lat, bs, da);
      vectors++; if (r !== be[i]) begin miscompares++; $display("FAIL boundary_%0d got=%h exp=%h", i, r, be[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone; int first_at; logic [63:0] r;
    ndone = 0; first_at = -1; r = '0;
    multiplicand = 32'd5; multiplier = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2; end
      else if (c == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first_at < 0) begin first_at = c; r = out; end
      end
    end
    $display("op m=5 q=9 with ignored start out=%h done_edge=%0d dones=%0d", r, first_at, ndone);
    vectors++; if (r !== 64'd45) begin miscompares++; $display("FAIL ignore_out got=%h exp=2d", r); end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    vectors++; if (first_at !== LAT) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=%0d", first_at, LAT); end
  endtask

  task automatic test_abort();
    logic [63:0] r; int lat; bit bs; logic da;
    multiplicand = 32'hFFFF_FFFA; multiplier = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    clr_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b exp=0", done); end
    vectors++; if (out !== 64'd0) begin miscompares++; $display("FAIL abort_out got=%h exp=0", out); end
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd3, 32'd3, r, lat, bs, da);
    vectors++; if (r !== 64'd9) begin miscompares++; $display("FAIL abort_recover_out got=%h exp=9", r); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL abort_recover_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int lat1; int lat2; logic [63:0] r1; logic [63:0] r2;
    multiplicand = 32'd6; multiplier = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF;
    lat1 = 0;
    while (done !== 1'b1 && lat1 < 100) begin @(posedge clk); #1; lat1++; end
    r1 = out;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_no_gap busy=%b exp=1", busy); end
    lat2 = 0;
    while (done !== 1'b1 && lat2 < 100) begin @(posedge clk); #1; lat2++; end
    r2 = out;
    $display("b2b first=%h edge=%0d second=%h edge=%0d", r1, lat1, r2, lat2 + 1);
    vectors++; if (r1 !== 64'd42) begin miscompares++; $display("FAIL b2b_first got=%h exp=2a", r1); end
    vectors++; if (lat1 !== LAT) begin miscompares++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat1, LAT); end
    vectors++; if (r2 !== 64'd1) begin miscompares++; $display("FAIL b2b_second got=%h exp=1", r2); end
    vectors++; if (lat2 !== LAT) begin miscompares++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [63:0] r; int lat; bit bs; logic da;
    do_op(32'd0, 32'h1234_5678, r, lat, bs, da);
    vectors++; if (r !== 64'd0) begin miscompares++; $display("FAIL zero_out got=%h exp=0", r); end
    vectors++; if (lat !== ZLAT) begin miscompares++; $display("FAIL zero_latency got=%0d exp=%0d", lat, ZLAT); end
    vectors++; if (bs !== ZBUSY) begin miscompares++; $display("FAIL zero_busy got=%b exp=%b", bs, ZBUSY); end
    vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL zero_single_done got=%b exp=0", da); end
  endtask

  task automatic test_random();
    logic [31:0] m; logic [31:0] q; logic [63:0] ex; logic [63:0] r; int lat; bit bs; logic da;
    for (int i = 0; i < 200; i++) begin
      m  = $urandom;
      q  = $urandom;
      ex = {{32{m[31]}}, m} * {{32{q[31]}}, q};
      do_op(m, q, r, lat, bs, da);
      vectors++; if (r !== ex || lat >= 100) begin
        miscompares++; $display("FAIL random_%0d got=%h exp=%h done_edge=%0d", i, r, ex, lat);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_zero();
    test_boundaries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
